// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its front-end detectors.
package traffic_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVED  = 2'd2,
      FAULT   = 2'd3
   } state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_STUCK_CYCLES    = 64;

endpackage

// File: rtl/vehicle_detector_if.sv
// Sensor/grant inputs and request/status outputs of the vehicle detector.
interface vehicle_detector_if #(
   parameter int CNT_W = 8
);
   logic             sensor_raw;
   logic             green;
   logic             car_detect;
   logic             sensor_clean;
   logic             fault;
   logic [CNT_W-1:0] req_count;

   modport master (
      output sensor_raw, green,
      input  car_detect, sensor_clean, fault, req_count
   );

   modport slave (
      input  sensor_raw, green,
      output car_detect, sensor_clean, fault, req_count
   );
endinterface

// File: rtl/sync_debounce.sv
// Multi-flop synchroniser followed by a stability counter; dout changes only after
// DEBOUNCE_CYCLES consecutive synchronised cycles that differ from it.
module sync_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   s;
   logic [DB_W-1:0]        db_cnt;

   assign s = sync_p0[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
         db_cnt  <= '0;
         dout    <= 1'b0;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
         if (s == dout) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            dout   <= s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/vehicle_detector.sv
// Turns a debounced loop sensor into a latched car_detect request, released by green,
// with one request per vehicle and a sticky fail-safe on a stuck sensor.
module vehicle_detector
   import traffic_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES,
   parameter int CNT_W           = 8
) (
   input logic               clk,
   input logic               reset,
   vehicle_detector_if.slave bus
);
   localparam int STUCK_W = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
   localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic               clean;
   state_t             state, state_nxt;
   logic               car_q, car_nxt;
   logic               fault_q, fault_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic [STUCK_W-1:0] stuck_q, stuck_nxt;

   sync_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_sync_debounce (
      .clk  (clk),
      .reset(reset),
      .din  (bus.sensor_raw),
      .dout (clean)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         car_q   <= 1'b0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
         stuck_q <= '0;
      end else begin
         state   <= state_nxt;
         car_q   <= car_nxt;
         fault_q <= fault_nxt;
         cnt_q   <= cnt_nxt;
         stuck_q <= stuck_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      car_nxt   = car_q;
      fault_nxt = fault_q;
      cnt_nxt   = cnt_q;
      stuck_nxt = stuck_q;
      case (state)
         IDLE: begin
            car_nxt = 1'b0;
            if (clean && bus.green) begin
               state_nxt = SERVED;
               stuck_nxt = '0;
            end else if (clean) begin
               state_nxt = REQUEST;
               car_nxt   = 1'b1;
               cnt_nxt   = sat_inc(cnt_q);
            end
         end
         REQUEST: begin
            car_nxt = 1'b1;
            // Grant takes priority over the car leaving in the same cycle.
            if (bus.green) begin
               state_nxt = SERVED;
               car_nxt   = 1'b0;
               stuck_nxt = '0;
            end else if (!clean) begin
               state_nxt = IDLE;
               car_nxt   = 1'b0;
            end
         end
         SERVED: begin
            car_nxt = 1'b0;
            if (!clean) begin
               state_nxt = IDLE;
            end else if (stuck_q == STUCK_LAST) begin
               state_nxt = FAULT;
               car_nxt   = 1'b1;
               fault_nxt = 1'b1;
            end else begin
               stuck_nxt = stuck_q + 1'b1;
            end
         end
         FAULT: begin
            // Keep requesting so the controller keeps cycling despite a dead sensor.
            car_nxt   = 1'b1;
            fault_nxt = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.car_detect   = car_q;
   assign bus.sensor_clean = clean;
   assign bus.fault        = fault_q;
   assign bus.req_count    = cnt_q;
endmodule

// File: tb/tb_vehicle_detector.sv
// Bench for vehicle_detector: pulse table with a scoreboard queue plus hand-written
// latency, grant, stuck-sensor, reset and saturation sequences.
module tb_vehicle_detector;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   exp_cnt = 0;

   always #5 clk = ~clk;

   vehicle_detector_if #(.CNT_W(CNT_W)) bus ();

   vehicle_detector #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .STUCK_CYCLES   (64),
      .CNT_W          (CNT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int   len;
      logic grn;
      logic exp_clean;
      logic exp_detect;
      logic inc;
   } vec_t;

   typedef struct {
      logic clean;
      logic detect;
      int   cnt;
   } sb_t;

   sb_t sb_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Drive one sensor pulse of len cycles and record whether clean/detect ever rose.
   task automatic pulse(input int len, input logic grn, output logic seen_c, output logic seen_d);
      seen_c = 1'b0;
      seen_d = 1'b0;
      @(negedge clk);
      bus.green      = grn;
      bus.sensor_raw = 1'b1;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         seen_c |= bus.sensor_clean;
         seen_d |= bus.car_detect;
      end
      bus.sensor_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         seen_c |= bus.sensor_clean;
         seen_d |= bus.car_detect;
      end
      bus.green = 1'b0;
   endtask

   task automatic wait_detect(input string name);
      int n;
      n = 0;
      while (!bus.car_detect && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!bus.car_detect) check(name, 0, 1);
   endtask

   initial begin
      vec_t vecs[8];
      sb_t  e, a;
      logic sc, sd;
      int   clean_edge, det_edge;

      vecs[0] = '{1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{2, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{3, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{4, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{6, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{3, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{5, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{8, 1'b0, 1'b1, 1'b1, 1'b1};

      bus.sensor_raw = 1'b1;
      bus.green      = 1'b0;

      // Reset held with the sensor active: nothing may move.
      for (int i = 0; i < 3; i++) begin
         repeat (3) @(negedge clk);
         check("rst_clean", bus.sensor_clean, 0);
         check("rst_detect", bus.car_detect, 0);
         check("rst_fault", bus.fault, 0);
         check("rst_count", bus.req_count, 0);
      end

      // Release and measure latency, edge 0 being the first rising edge after release.
      @(negedge clk);
      reset = 1'b1;
      clean_edge = -1;
      det_edge   = -1;
      for (int ed = 0; ed < 20; ed++) begin
         @(posedge clk);
         #1;
         if (bus.sensor_clean && clean_edge < 0) clean_edge = ed;
         if (bus.car_detect && det_edge < 0) det_edge = ed;
      end
      check("lat_clean_edge", clean_edge, 5);
      check("lat_detect_edge", det_edge, 6);
      exp_cnt = 1;
      check("lat_count", bus.req_count, exp_cnt);

      // Car leaves unserved: request drops.
      @(negedge clk);
      bus.sensor_raw = 1'b0;
      repeat (12) @(negedge clk);
      check("unserved_detect", bus.car_detect, 0);
      check("unserved_count", bus.req_count, exp_cnt);

      // Table of pulses through the scoreboard.
      foreach (vecs[i]) begin
         if (vecs[i].inc) exp_cnt++;
         e.clean  = vecs[i].exp_clean;
         e.detect = vecs[i].exp_detect;
         e.cnt    = exp_cnt;
         sb_q.push_back(e);
         pulse(vecs[i].len, vecs[i].grn, sc, sd);
         a.clean  = sc;
         a.detect = sd;
         a.cnt    = int'(bus.req_count);
         e = sb_q.pop_front();
         check($sformatf("vec%0d_clean", i), a.clean, e.clean);
         check($sformatf("vec%0d_detect", i), a.detect, e.detect);
         check($sformatf("vec%0d_count", i), a.cnt, e.cnt);
      end

      // Request then one-cycle grant; car stays, then leaves; second car re-requests.
      @(negedge clk);
      bus.sensor_raw = 1'b1;
      wait_detect("grant_wait1");
      exp_cnt++;
      check("grant_req1", bus.car_detect, 1);
      bus.green = 1'b1;
      @(posedge clk);
      #1;
      check("grant_drop", bus.car_detect, 0);
      @(negedge clk);
      bus.green = 1'b0;
      repeat (20) @(negedge clk);
      check("served_hold", bus.car_detect, 0);
      check("served_count", bus.req_count, exp_cnt);
      bus.sensor_raw = 1'b0;
      repeat (12) @(negedge clk);
      bus.sensor_raw = 1'b1;
      wait_detect("grant_wait2");
      exp_cnt++;
      check("second_car_detect", bus.car_detect, 1);
      check("second_car_count", bus.req_count, exp_cnt);

      // Grant the second car and keep the sensor stuck high.
      bus.green = 1'b1;
      @(negedge clk);
      bus.green = 1'b0;
      repeat (58) @(negedge clk);
      check("stuck_early_fault", bus.fault, 0);
      check("stuck_early_detect", bus.car_detect, 0);
      repeat (12) @(negedge clk);
      check("stuck_fault", bus.fault, 1);
      check("stuck_detect", bus.car_detect, 1);
      check("stuck_count", bus.req_count, exp_cnt);
      bus.sensor_raw = 1'b0;
      repeat (20) @(negedge clk);
      check("fault_sticky", bus.fault, 1);
      check("fault_detect_sticky", bus.car_detect, 1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("fault_rst_fault", bus.fault, 0);
      check("fault_rst_detect", bus.car_detect, 0);
      @(negedge clk);
      reset = 1'b1;
      exp_cnt = 0;

      // Asynchronous reset in the middle of a request.
      bus.sensor_raw = 1'b1;
      wait_detect("midreq_wait");
      check("midreq_pre_count", bus.req_count, 1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("midreq_detect", bus.car_detect, 0);
      check("midreq_clean", bus.sensor_clean, 0);
      check("midreq_count", bus.req_count, 0);
      bus.sensor_raw = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      // Saturation: more requests than the counter can hold.
      for (int i = 0; i < 260; i++) begin
         pulse(5, 1'b0, sc, sd);
         if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
         if (i == 254) check("sat_reach", bus.req_count, exp_cnt);
      end
      check("sat_hold", bus.req_count, exp_cnt);
      check("sat_value", bus.req_count, 255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
